ctrl_unit_pipelined: RTL

//  Registered, stall-aware control unit; successor to the combinational opcode decoder.

---
 rtl/cpu_ctrl_pkg.sv | 56 +++++
 rtl/ctrl_decode_rom.sv | 108 ++++++++++
 rtl/ctrl_unit_pipelined.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the pipelined CPU control unit.
// Opcode map, ALU function codes, the 13-bit control word and the FSM state encoding.
package cpu_ctrl_pkg;

   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;
   localparam logic [7:0] OP_J     = 8'h06;
   localparam logic [7:0] OP_BEQ   = 8'h07;
   localparam logic [7:0] OP_MULT  = 8'h08;
   localparam logic [7:0] OP_SLL   = 8'h09;
   localparam logic [7:0] OP_SRL   = 8'h0A;
   localparam logic [7:0] OP_SRA   = 8'h0B;
   localparam logic [7:0] OP_ROR   = 8'h0C;
   localparam logic [7:0] OP_BNE   = 8'h0D;
   localparam logic [7:0] OP_LWD   = 8'h0E;
   localparam logic [7:0] OP_LWI   = 8'h0F;
   localparam logic [7:0] OP_SWD   = 8'h10;
   localparam logic [7:0] OP_SWI   = 8'h11;

   localparam logic [3:0] ALU_FWD = 4'd0;
   localparam logic [3:0] ALU_ADD = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_MUL = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6;
   localparam logic [3:0] ALU_SRA = 4'd7;
   localparam logic [3:0] ALU_ROR = 4'd8;

   typedef struct packed {
      logic       branchneq;
      logic       branch;
      logic       jump;
      logic       rf_out_sel;
      logic       alu_in_sel;
      logic       write_enable;
      logic       alu_out_sel;
      logic       read;
      logic       write;
      logic [3:0] aluop;
   } ctrl_word_t;

   localparam ctrl_word_t CTRL_BUBBLE = '0;

   typedef enum logic [1:0] {
      DECODE = 2'd0,
      MEM    = 2'd1,
      FLUSH  = 2'd2,
      HALT   = 2'd3
   } state_t;

endpackage

// File: rtl/ctrl_decode_rom.sv
// Combinational opcode decoder: opcode -> control word plus an illegal-opcode flag.
// Every field not named for an opcode stays 0, so the output never carries X.
module ctrl_decode_rom
   import cpu_ctrl_pkg::*;
#(
   parameter int OPCODE_WIDTH = 8
) (
   input  logic [OPCODE_WIDTH-1:0] opcode_i,
   output ctrl_word_t              word_o,
   output logic                    illegal_o
);

   always_comb begin
      word_o    = CTRL_BUBBLE;
      illegal_o = 1'b0;
      case (opcode_i)
         OPCODE_WIDTH'(OP_LOADI): begin
            word_o.write_enable = 1'b1;
            word_o.aluop        = ALU_FWD;
         end
         OPCODE_WIDTH'(OP_MOV): begin
            word_o.alu_in_sel   = 1'b1;
            word_o.write_enable = 1'b1;
            word_o.aluop        = ALU_FWD;
         end
         OPCODE_WIDTH'(OP_ADD): begin
            word_o.alu_in_sel   = 1'b1;
            word_o.write_enable = 1'b1;
            word_o.aluop        = ALU_ADD;
         end
         OPCODE_WIDTH'(OP_SUB): begin
            word_o.rf_out_sel   = 1'b1;
            word_o.alu_in_sel   = 1'b1;
            word_o.write_enable = 1'b1;
            word_o.aluop        = ALU_ADD;
         end
         OPCODE_WIDTH'(OP_AND): begin
            word_o.alu_in_sel   = 1'b1;
            word_o.write_enable = 1'b1;
            word_o.aluop        = ALU_AND;
         end
         OPCODE_WIDTH'(OP_OR): begin
            word_o.alu_in_sel   = 1'b1;
            word_o.write_enable = 1'b1;
            word_o.aluop        = ALU_OR;
         end
         OPCODE_WIDTH'(OP_J): begin
            word_o.jump = 1'b1;
         end
         OPCODE_WIDTH'(OP_BEQ): begin
            word_o.branch     = 1'b1;
            word_o.alu_in_sel = 1'b1;
            word_o.aluop      = ALU_ADD;
         end
         OPCODE_WIDTH'(OP_MULT): begin
            word_o.alu_in_sel   = 1'b1;
            word_o.write_enable = 1'b1;
            word_o.aluop        = ALU_MUL;
         end
         OPCODE_WIDTH'(OP_SLL): begin
            word_o.write_enable = 1'b1;
            word_o.aluop        = ALU_SLL;
         end
         OPCODE_WIDTH'(OP_SRL): begin
            word_o.write_enable = 1'b1;
            word_o.aluop        = ALU_SRL;
         end
         OPCODE_WIDTH'(OP_SRA): begin
            word_o.write_enable = 1'b1;
            word_o.aluop        = ALU_SRA;
         end
         OPCODE_WIDTH'(OP_ROR): begin
            word_o.write_enable = 1'b1;
            word_o.aluop        = ALU_ROR;
         end
         OPCODE_WIDTH'(OP_BNE): begin
            word_o.branchneq  = 1'b1;
            word_o.alu_in_sel = 1'b1;
            word_o.aluop      = ALU_ADD;
         end
         // Loads write back memory data, so the writeback mux selects the memory side.
         OPCODE_WIDTH'(OP_LWD): begin
            word_o.alu_in_sel   = 1'b1;
            word_o.write_enable = 1'b1;
            word_o.alu_out_sel  = 1'b1;
            word_o.read         = 1'b1;
         end
         OPCODE_WIDTH'(OP_LWI): begin
            word_o.write_enable = 1'b1;
            word_o.alu_out_sel  = 1'b1;
            word_o.read         = 1'b1;
         end
         OPCODE_WIDTH'(OP_SWD): begin
            word_o.alu_in_sel = 1'b1;
            word_o.write      = 1'b1;
         end
         // swi keeps BRANCHNEQ high: legacy encoding expected by the datapath.
         OPCODE_WIDTH'(OP_SWI): begin
            word_o.branchneq = 1'b1;
            word_o.write     = 1'b1;
         end
         default: begin
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/ctrl_unit_pipelined.sv
// Registered, stall-aware CPU control unit: 1-cycle decode, MEM hold on BUSYWAIT, post-branch flush.
// Optional feature macro ILLEGAL_OP_TRAP_EN adds the ILLEGAL output and a sticky HALT state.
module ctrl_unit_pipelined
   import cpu_ctrl_pkg::*;
#(
   parameter int INSTR_WIDTH    = 32,
   parameter int OPCODE_LSB     = 24,
   parameter int OPCODE_WIDTH   = 8,
   parameter int ALUOP_WIDTH    = 4,
   parameter int MEM_MIN_CYCLES = 1,
   parameter int FLUSH_CYCLES   = 1
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [INSTR_WIDTH-1:0] INSTRUCTION,
   input  logic                   INSTR_VALID,
   input  logic                   BUSYWAIT,
   input  logic                   BRANCH_TAKEN,
   output logic                   BRANCHNEQ,
   output logic                   BRANCH,
   output logic                   JUMP,
   output logic                   RfOutSel,
   output logic                   AluInSel,
   output logic                   WRITEENABLE,
   output logic                   AluOutSel,
   output logic                   READ,
   output logic                   WRITE,
   output logic [ALUOP_WIDTH-1:0] ALUOP,
   output logic                   CTRL_VALID,
   output logic                   STALL
`ifdef ILLEGAL_OP_TRAP_EN
   ,
   output logic                   ILLEGAL
`endif
);

   localparam logic [4:0] MEM_MIN    = 5'(MEM_MIN_CYCLES);
   localparam logic [3:0] MEM_SAT    = 4'(MEM_MIN_CYCLES);
   localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

   state_t     state_q, state_d;
   ctrl_word_t word_q, word_d;
   logic       valid_q, valid_d;
   logic [3:0] mem_cnt_q, mem_cnt_d;
   logic [2:0] flush_cnt_q, flush_cnt_d;
`ifdef ILLEGAL_OP_TRAP_EN
   logic       illegal_q, illegal_d;
`endif

   ctrl_word_t rom_word;
   logic       rom_illegal;
   logic       mem_exit;
   logic       do_decode;
   logic       unused_instr;

   ctrl_decode_rom #(
      .OPCODE_WIDTH (OPCODE_WIDTH)
   ) u_rom (
      .opcode_i  (INSTRUCTION[OPCODE_LSB +: OPCODE_WIDTH]),
      .word_o    (rom_word),
      .illegal_o (rom_illegal)
   );

   // Operand fields are consumed by the datapath, not here.
   assign unused_instr = ^INSTRUCTION;

   // mem_cnt_q counts completed MEM cycles, so +1 includes the current one.
   assign mem_exit = (({1'b0, mem_cnt_q} + 5'd1) >= MEM_MIN) && !BUSYWAIT;

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      valid_d     = valid_q;
      mem_cnt_d   = mem_cnt_q;
      flush_cnt_d = flush_cnt_q;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_d   = illegal_q;
`endif
      do_decode   = 1'b0;

      case (state_q)
         DECODE: begin
            if (valid_q && BRANCH_TAKEN) begin
               word_d      = CTRL_BUBBLE;
               valid_d     = 1'b0;
               flush_cnt_d = 3'd0;
               state_d     = FLUSH;
            end else begin
               do_decode = 1'b1;
            end
         end
         MEM: begin
            if (mem_exit) begin
               word_d    = CTRL_BUBBLE;
               valid_d   = 1'b0;
               mem_cnt_d = 4'd0;
               state_d   = DECODE;
            end else if (mem_cnt_q < MEM_SAT) begin
               mem_cnt_d = mem_cnt_q + 4'd1;
            end
         end
         FLUSH: begin
            // The last flush cycle already accepts the branch-target instruction.
            if (flush_cnt_q == FLUSH_LAST) begin
               do_decode = 1'b1;
            end else begin
               flush_cnt_d = flush_cnt_q + 3'd1;
            end
         end
`ifdef ILLEGAL_OP_TRAP_EN
         HALT: begin
            word_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
         end
`endif
         default: begin
            word_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
            state_d = DECODE;
         end
      endcase

      if (do_decode) begin
         state_d     = DECODE;
         flush_cnt_d = 3'd0;
         if (!INSTR_VALID) begin
            word_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
         end else if (rom_illegal) begin
            word_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
            state_d   = HALT;
            illegal_d = 1'b1;
`endif
         end else begin
            word_d  = rom_word;
            valid_d = 1'b1;
            if (rom_word.read || rom_word.write) begin
               mem_cnt_d = 4'd0;
               state_d   = MEM;
            end
         end
      end
   end

   always_comb begin
      STALL = 1'b0;
      case (state_q)
         MEM:     STALL = !mem_exit;
`ifdef ILLEGAL_OP_TRAP_EN
         HALT:    STALL = 1'b1;
`endif
         default: STALL = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= DECODE;
         word_q      <= CTRL_BUBBLE;
         valid_q     <= 1'b0;
         mem_cnt_q   <= 4'd0;
         flush_cnt_q <= 3'd0;
`ifdef ILLEGAL_OP_TRAP_EN
         illegal_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         valid_q     <= valid_d;
         mem_cnt_q   <= mem_cnt_d;
         flush_cnt_q <= flush_cnt_d;
`ifdef ILLEGAL_OP_TRAP_EN
         illegal_q   <= illegal_d;
`endif
      end
   end

   assign BRANCHNEQ   = word_q.branchneq;
   assign BRANCH      = word_q.branch;
   assign JUMP        = word_q.jump;
   assign RfOutSel    = word_q.rf_out_sel;
   assign AluInSel    = word_q.alu_in_sel;
   assign WRITEENABLE = word_q.write_enable;
   assign AluOutSel   = word_q.alu_out_sel;
   assign READ        = word_q.read;
   assign WRITE       = word_q.write;
   assign ALUOP       = ALUOP_WIDTH'(word_q.aluop);
   assign CTRL_VALID  = valid_q;
`ifdef ILLEGAL_OP_TRAP_EN
   assign ILLEGAL     = illegal_q;
`endif

endmodule
